// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Stage-word field widths, bubble word and cell select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int STAT_W  = 3;
    localparam int ICODE_W = 4;
    localparam int VAL_W   = 64;
    localparam int REG_W   = 4;
    localparam int WORD_W  = STAT_W + ICODE_W + 2 * VAL_W + 2 * REG_W;

    localparam logic [STAT_W-1:0]  STAT_AOK  = 3'd1;
    localparam logic [ICODE_W-1:0] ICODE_NOP = 4'd1;
    localparam logic [REG_W-1:0]   RNONE     = 4'hF;

    // {stat, icode, valE, valM, dstE, dstM}, MSB first
    localparam logic [WORD_W-1:0] BUBBLE_WORD = {STAT_AOK, ICODE_NOP,
                                                 {VAL_W{1'b0}}, {VAL_W{1'b0}},
                                                 RNONE, RNONE};

    typedef enum logic [1:0] {
        CELL_HOLD  = 2'd0,
        CELL_LOAD  = 2'd1,
        CELL_CLEAR = 2'd2
    } cell_op_e;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_cell.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_cell
// Description : One {valid, word} pipeline register with hold/load/clear select.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = WORD_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = BUBBLE_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        i_op,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_word
);

    logic              r_valid;
    logic [DATA_W-1:0] r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_word  <= BUBBLE_VAL;
        end else begin
            case (i_op)
                CELL_LOAD: begin
                    r_valid <= i_valid;
                    r_word  <= i_word;
                end
                CELL_CLEAR: begin
                    r_valid <= 1'b0;
                    r_word  <= BUBBLE_VAL;
                end
                default: begin
                    r_valid <= r_valid;
                    r_word  <= r_word;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : DEPTH-stage pipeline register chain with stall/bubble/flush,
//               occupancy count and optional perf counters (PIPE_PERF_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = WORD_W,
    parameter int                DEPTH      = 1,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = BUBBLE_WORD
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         bubble,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  bubble_cnt
);

    localparam int                 c_occ_w   = $clog2(DEPTH + 1);
    localparam logic [c_occ_w-1:0] c_occ_one = c_occ_w'(1);

    logic              w_stage_valid [DEPTH];
    logic [DATA_W-1:0] w_stage_word  [DEPTH];

    // A bubble pushes the chain forward even while stalled.
    logic w_adv;
    assign w_adv = bubble | ~stall;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              w_d_valid;
        logic [DATA_W-1:0] w_d_word;
        logic [1:0]        w_op;

        if (k == 0) begin : g_head
            assign w_d_valid = in_valid;
            assign w_d_word  = in_data;
            assign w_op      = (flush | bubble) ? CELL_CLEAR :
                               (stall ? CELL_HOLD : CELL_LOAD);
        end else begin : g_body
            assign w_d_valid = w_stage_valid[k-1];
            assign w_d_word  = w_stage_word[k-1];
            assign w_op      = flush ? CELL_CLEAR :
                               (w_adv ? CELL_LOAD : CELL_HOLD);
        end

        pipe_stage_cell #(
            .DATA_W     (DATA_W),
            .BUBBLE_VAL (BUBBLE_VAL)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .i_op    (w_op),
            .i_valid (w_d_valid),
            .i_word  (w_d_word),
            .o_valid (w_stage_valid[k]),
            .o_word  (w_stage_word[k])
        );
    end

    assign out_valid = w_stage_valid[DEPTH-1];
    assign out_data  = w_stage_word[DEPTH-1];

    logic               w_occ_in;
    logic               w_occ_out;
    logic [c_occ_w-1:0] r_occ;

    assign w_occ_in  = ~flush & ~bubble & ~stall & in_valid;
    assign w_occ_out = w_adv & w_stage_valid[DEPTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_occ_in & ~w_occ_out) begin
            r_occ <= r_occ + c_occ_one;
        end else if (~w_occ_in & w_occ_out) begin
            r_occ <= r_occ - c_occ_one;
        end
    end

    assign occ = r_occ;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [31:0] c_cnt_max = 32'hFFFF_FFFF;

    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (stall & ~flush & ~bubble & (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((bubble | flush) & (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, 143, stage word width; default packs {stat[2:0], icode[3:0], valE[63:0], valM[63:0], dstE[3:0], dstM[3:0]}, MSB first.
REQ-002 Parameter DEPTH, 1, number of register stages in the chain; legal range 1..8.
REQ-003 Parameter BUBBLE_VAL, pipe_pkg::BUBBLE_WORD, word loaded on bubble/flush/reset: stat=AOK(1), icode=NOP(1), valE=valM=0, dstE=dstM=RNONE(4'hF).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hold every stage unchanged.
REQ-007 bubble  input  1  load BUBBLE_VAL into stage 0 instead of in_data.
REQ-008 flush  input  1  load BUBBLE_VAL into all stages.
REQ-009 in_valid  input  1  in_data carries a real instruction.
REQ-010 in_data  input  DATA_W  incoming stage word.
REQ-011 out_valid  output  1  valid flag of last stage.
REQ-012 out_data  output  DATA_W  word of last stage.
REQ-013 occ  output  $clog2(DEPTH+1)  count of stages holding valid=1.
REQ-014 stall_cnt  output  32  stall-cycle counter (see Configuration).
REQ-015 bubble_cnt  output  32  bubble/flush-cycle counter (see Configuration).

Function
REQ-016 Each stage SHALL hold {valid, word}; out_valid/out_data SHALL be driven directly from stage DEPTH-1 flops (no combinational path from inputs).
REQ-017 Latency SHALL be DEPTH cycles from in_data sampled to out_data, absent stall.
REQ-018 Priority per edge SHALL be: flush > bubble > stall > normal advance.
REQ-019 Normal advance: stage0 <= {in_valid, in_data}; stage k <= stage k-1 for k=1..DEPTH-1.
REQ-020 stall=1 (no flush/bubble): all stages SHALL retain value; in_data ignored.
REQ-021 bubble=1 (no flush): stage0 <= {0, BUBBLE_VAL}; stages 1..DEPTH-1 SHALL advance even if stall=1.
REQ-022 flush=1: every stage <= {0, BUBBLE_VAL} in one cycle, regardless of stall/bubble.
REQ-023 occ SHALL be a registered counter updated same edge as stages: +1 when valid enters stage0 and none leaves last stage, -1 for the converse, unchanged otherwise or under stall; 0 on flush.
REQ-024 occ SHALL never exceed DEPTH nor underflow; it SHALL equal popcount of stage valid bits every cycle.
REQ-025 in_valid=0 with no bubble SHALL still load in_data but mark stage invalid.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) set all stages to {0, BUBBLE_VAL}, occ=0, stall_cnt=0, bubble_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight words; first capture occurs on first rising clk edge after reset deasserts.

Configuration
REQ-028 Macro PIPE_PERF_CNT_EN defined: stall_cnt SHALL increment on each edge with stall=1 and no flush/bubble; bubble_cnt SHALL increment on each edge with bubble=1 or flush=1; both saturate at 32'hFFFF_FFFF.
REQ-029 Macro PIPE_PERF_CNT_EN undefined: counter flops SHALL be absent and stall_cnt/bubble_cnt SHALL be tied to 0; ports remain present.

Structure
REQ-030 Package pipe_pkg SHALL hold STAT_AOK, ICODE_NOP, RNONE, field widths, and BUBBLE_WORD.
REQ-031 One sub-module pipe_stage_cell (single {valid, word} register with load/hold/bubble select) SHALL be instantiated DEPTH times via generate.

Verification
REQ-032 DEPTH=3, in_data=0x1..0x5 with in_valid=1 on consecutive cycles -> out_data 0x1..0x5 appear cycles 3..7, occ reaches 3.
REQ-033 DEPTH=1, load 0xAB, stall=1 for 4 cycles -> out_data stays 0xAB, stall_cnt=4 (macro on) / 0 (macro off).
REQ-034 DEPTH=2, stall=1 and bubble=1 same cycle -> stage0 becomes BUBBLE_VAL valid=0, stage1 advances, bubble_cnt=1, stall_cnt unchanged.
REQ-035 DEPTH=4 full of valid words, flush=1 with stall=1 -> next cycle out_valid=0, out_data=BUBBLE_VAL, occ=0.
REQ-036 reset pulsed between clock edges while occ=2 -> out_valid=0, occ=0, counters 0 before next edge.
REQ-037 Counter saturation: preload stall_cnt near limit via force, 3 stall cycles -> holds 32'hFFFF_FFFF.
